// File: rtl/sha512_compress_ctrl.sv
// sha512_compress_ctrl: sequences the SHA-512 compression of one 1024-bit block,
// one round per clock, and owns the W schedule, K lookup and chaining hash H.
// Optional feature macro: SHA512_ABORT_EN adds an abort input that cancels a block
// in progress and returns to IDLE with H left unchanged.
module sha512_compress_ctrl #(
  parameter int unsigned NROUNDS = 80
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          blk_valid,
  output logic          blk_ready,
  input  logic [1023:0] blk_data,
  input  logic          blk_first,
  output logic          dig_valid,
  input  logic          dig_ready,
  output logic [511:0]  dig_data,
  output logic          busy
`ifdef SHA512_ABORT_EN
  ,
  input  logic          abort
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [6:0] LAST_ROUND = 7'(NROUNDS - 1);

  // ---------------------------------------------------------------- helpers
  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    logic [127:0] t;
    t = {x, x} >> n;
    return t[63:0];
  endfunction

  function automatic logic [63:0] big_sig0(input logic [63:0] x);
    return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
  endfunction

  function automatic logic [63:0] big_sig1(input logic [63:0] x);
    return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
  endfunction

  function automatic logic [63:0] sml_sig0(input logic [63:0] x);
    return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sml_sig1(input logic [63:0] x);
    return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  function automatic logic [63:0] h0_word(input logic [2:0] i);
    case (i)
      3'd0:    return 64'h6a09e667f3bcc908;
      3'd1:    return 64'hbb67ae8584caa73b;
      3'd2:    return 64'h3c6ef372fe94f82b;
      3'd3:    return 64'ha54ff53a5f1d36f1;
      3'd4:    return 64'h510e527fade682d1;
      3'd5:    return 64'h9b05688c2b3e6c1f;
      3'd6:    return 64'h1f83d9abfb41bd6b;
      3'd7:    return 64'h5be0cd19137e2179;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] k_const(input logic [6:0] i);
    case (i)
      7'd0:  return 64'h428a2f98d728ae22;  7'd1:  return 64'h7137449123ef65cd;
      7'd2:  return 64'hb5c0fbcfec4d3b2f;  7'd3:  return 64'he9b5dba58189dbbc;
      7'd4:  return 64'h3956c25bf348b538;  7'd5:  return 64'h59f111f1b605d019;
      7'd6:  return 64'h923f82a4af194f9b;  7'd7:  return 64'hab1c5ed5da6d8118;
      7'd8:  return 64'hd807aa98a3030242;  7'd9:  return 64'h12835b0145706fbe;
      7'd10: return 64'h243185be4ee4b28c;  7'd11: return 64'h550c7dc3d5ffb4e2;
      7'd12: return 64'h72be5d74f27b896f;  7'd13: return 64'h80deb1fe3b1696b1;
      7'd14: return 64'h9bdc06a725c71235;  7'd15: return 64'hc19bf174cf692694;
      7'd16: return 64'he49b69c19ef14ad2;  7'd17: return 64'hefbe4786384f25e3;
      7'd18: return 64'h0fc19dc68b8cd5b5;  7'd19: return 64'h240ca1cc77ac9c65;
      7'd20: return 64'h2de92c6f592b0275;  7'd21: return 64'h4a7484aa6ea6e483;
      7'd22: return 64'h5cb0a9dcbd41fbd4;  7'd23: return 64'h76f988da831153b5;
      7'd24: return 64'h983e5152ee66dfab;  7'd25: return 64'ha831c66d2db43210;
      7'd26: return 64'hb00327c898fb213f;  7'd27: return 64'hbf597fc7beef0ee4;
      7'd28: return 64'hc6e00bf33da88fc2;  7'd29: return 64'hd5a79147930aa725;
      7'd30: return 64'h06ca6351e003826f;  7'd31: return 64'h142929670a0e6e70;
      7'd32: return 64'h27b70a8546d22ffc;  7'd33: return 64'h2e1b21385c26c926;
      7'd34: return 64'h4d2c6dfc5ac42aed;  7'd35: return 64'h53380d139d95b3df;
      7'd36: return 64'h650a73548baf63de;  7'd37: return 64'h766a0abb3c77b2a8;
      7'd38: return 64'h81c2c92e47edaee6;  7'd39: return 64'h92722c851482353b;
      7'd40: return 64'ha2bfe8a14cf10364;  7'd41: return 64'ha81a664bbc423001;
      7'd42: return 64'hc24b8b70d0f89791;  7'd43: return 64'hc76c51a30654be30;
      7'd44: return 64'hd192e819d6ef5218;  7'd45: return 64'hd69906245565a910;
      7'd46: return 64'hf40e35855771202a;  7'd47: return 64'h106aa07032bbd1b8;
      7'd48: return 64'h19a4c116b8d2d0c8;  7'd49: return 64'h1e376c085141ab53;
      7'd50: return 64'h2748774cdf8eeb99;  7'd51: return 64'h34b0bcb5e19b48a8;
      7'd52: return 64'h391c0cb3c5c95a63;  7'd53: return 64'h4ed8aa4ae3418acb;
      7'd54: return 64'h5b9cca4f7763e373;  7'd55: return 64'h682e6ff3d6b2b8a3;
      7'd56: return 64'h748f82ee5defb2fc;  7'd57: return 64'h78a5636f43172f60;
      7'd58: return 64'h84c87814a1f0ab72;  7'd59: return 64'h8cc702081a6439ec;
      7'd60: return 64'h90befffa23631e28;  7'd61: return 64'ha4506cebde82bde9;
      7'd62: return 64'hbef9a3f7b2c67915;  7'd63: return 64'hc67178f2e372532b;
      7'd64: return 64'hca273eceea26619c;  7'd65: return 64'hd186b8c721c0c207;
      7'd66: return 64'heada7dd6cde0eb1e;  7'd67: return 64'hf57d4f7fee6ed178;
      7'd68: return 64'h06f067aa72176fba;  7'd69: return 64'h0a637dc5a2c898a6;
      7'd70: return 64'h113f9804bef90dae;  7'd71: return 64'h1b710b35131c471b;
      7'd72: return 64'h28db77f523047d84;  7'd73: return 64'h32caab7b40c72493;
      7'd74: return 64'h3c9ebe0a15c9bebc;  7'd75: return 64'h431d67c49c100d4c;
      7'd76: return 64'h4cc5d4becb3e42b6;  7'd77: return 64'h597f299cfc657e2a;
      7'd78: return 64'h5fcb6fab3ad6faec;  7'd79: return 64'h6c44198c4a475817;
      default: return 64'h0;
    endcase
  endfunction

  // ---------------------------------------------------------------- state
  state_e            state_q;
  logic [6:0]        round_q;
  logic              blk_ready_q, dig_valid_q, busy_q;
  logic [63:0]       k_q;
  logic [15:0][63:0] w_q, w_d;
  logic [7:0][63:0]  var_q, var_d;   // index 0 = a ... 7 = h
  logic [7:0][63:0]  base_q, base_d;
  logic [7:0][63:0]  h_q, h_d;

  logic              abort_s;
  logic              accept_s;
  logic [6:0]        k_addr_s;
  logic [63:0]       t1_s, t2_s, w_new_s;

`ifdef SHA512_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign accept_s  = (state_q == ST_IDLE) && blk_valid && blk_ready_q;
  assign blk_ready = blk_ready_q;
  assign dig_valid = dig_valid_q;
  assign busy      = busy_q;

  // K address runs one ahead of the round so the registered K lands on time.
  always_comb begin
    k_addr_s = 7'd0;
    if ((state_q == ST_ROUND) && (round_q != LAST_ROUND)) begin
      k_addr_s = round_q + 7'd1;
    end else begin
      k_addr_s = 7'd0;
    end
  end

  // One compression round, the W recurrence and the chaining add.
  always_comb begin
    t1_s = var_q[7] + big_sig1(var_q[4])
         + ((var_q[4] & var_q[5]) ^ (~var_q[4] & var_q[6]))
         + k_q + w_q[0];
    t2_s = big_sig0(var_q[0])
         + ((var_q[0] & var_q[1]) ^ (var_q[0] & var_q[2]) ^ (var_q[1] & var_q[2]));
    w_new_s = sml_sig1(w_q[14]) + w_q[9] + sml_sig0(w_q[1]) + w_q[0];

    var_d  = var_q;
    base_d = base_q;
    w_d    = w_q;
    h_d    = h_q;
    if (accept_s) begin
      for (int i = 0; i < 16; i++) begin
        w_d[i] = blk_data[1023 - 64*i -: 64];
      end
      for (int i = 0; i < 8; i++) begin
        var_d[i]  = blk_first ? h0_word(3'(i)) : h_q[i];
        base_d[i] = blk_first ? h0_word(3'(i)) : h_q[i];
      end
    end else if ((state_q == ST_ROUND) && !abort_s) begin
      var_d[0] = t1_s + t2_s;
      var_d[1] = var_q[0];
      var_d[2] = var_q[1];
      var_d[3] = var_q[2];
      var_d[4] = var_q[3] + t1_s;
      var_d[5] = var_q[4];
      var_d[6] = var_q[5];
      var_d[7] = var_q[6];
      for (int i = 0; i < 15; i++) begin
        w_d[i] = w_q[i+1];
      end
      w_d[15] = w_new_s;
    end else if ((state_q == ST_FINAL) && !abort_s) begin
      for (int i = 0; i < 8; i++) begin
        h_d[i] = base_q[i] + var_q[i];
      end
    end else begin
      var_d = var_q;
    end
  end

  // Digest output is H, H0 in the top word.
  always_comb begin
    dig_data = 512'd0;
    for (int i = 0; i < 8; i++) begin
      dig_data[511 - 64*i -: 64] = h_q[i];
    end
  end

  // Datapath registers: working vars, base, W window, H and the K lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      var_q  <= '0;
      base_q <= '0;
      w_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= h0_word(3'(i));
      end
      k_q    <= 64'd0;
    end else begin
      var_q  <= var_d;
      base_q <= base_d;
      w_q    <= w_d;
      h_q    <= h_d;
      k_q    <= k_const(k_addr_s);
    end
  end

  // Control FSM with its registered handshake outputs and round counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      round_q     <= 7'd0;
      blk_ready_q <= 1'b1;
      dig_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q     <= ST_ROUND;
            round_q     <= 7'd0;
            blk_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_ROUND: begin
          if (abort_s) begin
            state_q     <= ST_IDLE;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (round_q == LAST_ROUND) begin
            state_q <= ST_FINAL;
          end else begin
            round_q <= round_q + 7'd1;
          end
        end
        ST_FINAL: begin
          if (abort_s) begin
            state_q     <= ST_IDLE;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            dig_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (dig_ready) begin
            state_q     <= ST_IDLE;
            dig_valid_q <= 1'b0;
            blk_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          round_q     <= 7'd0;
          blk_ready_q <= 1'b1;
          dig_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
